serial_bus_arbiter: RTL

Arbitrates ownership of the shared serial bus (`control`/`wD`/`valid`/`last` toward the slaves, `rD`/`ready` back) between `MASTERS` requesting masters. It grants one master at a time with round-robin fairness and routes that master's serial lines onto the bus. It forces a one-cycle idle gap between owners so every `111` start sequence is preceded by a low `control` line. Ownership is revoked after a hold timeout. The block sits between the master instances and the slave instances in the top module.

---
 rtl/serial_bus_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_bus_arbiter.sv
// Round-robin owner arbitration for the shared serial bus, with a forced idle gap
// between owners and a hold timeout that revokes ownership.
module serial_bus_arbiter #(
   parameter int MASTERS = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [MASTERS-1:0] req,
   output logic [MASTERS-1:0] grant,
   input  logic [MASTERS-1:0] m_control,
   input  logic [MASTERS-1:0] m_wD,
   input  logic [MASTERS-1:0] m_valid,
   input  logic [MASTERS-1:0] m_last,
   output logic [MASTERS-1:0] m_rD,
   output logic [MASTERS-1:0] m_ready,
   output logic               bus_control,
   output logic               bus_wD,
   output logic               bus_valid,
   output logic               bus_last,
   input  logic               bus_rD,
   input  logic               bus_ready,
   output logic               timeout,
   output logic [1:0]         state
);
   localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]      rr_ptr, rr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               timeout_q, timeout_d;
   logic               found;
   logic [PW-1:0]      sel;
   int                 idx;

   // First requester at or above rr_ptr, wrapping.
   always_comb begin : pick
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int i = 0; i < MASTERS; i++) begin
         idx = (int'(rr_ptr) + i) % MASTERS;
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
   end

   always_comb begin : next_state
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_ptr;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d      = '0;
               grant_d[sel] = 1'b1;
               rr_d         = (sel == PW'(MASTERS - 1)) ? '0 : sel + PW'(1);
               cnt_d        = '0;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CW'(1);
            // A voluntary drop wins over an expiring hold, so no timeout pulse then.
            if ((req & grant_q) == '0) begin
               state_d = RELEASE;
               grant_d = '0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d   = RELEASE;
               grant_d   = '0;
               timeout_d = 1'b1;
            end
         end
         RELEASE: state_d = IDLE;
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr    <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr    <= rr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Zero-delay routing from the registered one-hot grant.
   assign bus_control = |(m_control & grant_q);
   assign bus_wD      = |(m_wD & grant_q);
   assign bus_valid   = |(m_valid & grant_q);
   assign bus_last    = |(m_last & grant_q);
   assign m_rD        = grant_q & {MASTERS{bus_rD}};
   assign m_ready     = grant_q & {MASTERS{bus_ready}};

   assign grant   = grant_q;
   assign timeout = timeout_q;
   assign state   = state_q;
endmodule
